// File: rtl/elevator_pkg.sv
// elevator_pkg: shared definitions for the elevator group dispatcher.
//   - car state encodings as reported by each elevator_control car
//   - N_SLOTS: 7 hall up calls (floors 1..7) followed by 7 hall down calls (floors 2..8)
//   - dispatch_state_e: dispatcher FSM states
//   - onehot_to_idx: one-hot car position to floor 1..8, 0 when not one-hot
//   - slot_to_floor: call slot 0..13 to its target floor
package elevator_pkg;

  localparam logic [1:0] ST_OPEN  = 2'b00;
  localparam logic [1:0] ST_DN    = 2'b01;
  localparam logic [1:0] ST_UP    = 2'b10;
  localparam logic [1:0] ST_CLOSE = 2'b11;

  localparam int N_SLOTS = 14;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_PICK  = 2'd1,
    DS_ISSUE = 2'd2
  } dispatch_state_e;

  function automatic logic [3:0] onehot_to_idx(input logic [7:0] f);
    logic [3:0] idx;
    idx = 4'd0;
    if ($onehot(f)) begin
      for (int i = 0; i < 8; i++) begin
        if (f[i]) idx = 4'(i + 1);
      end
    end
    return idx;
  endfunction

  // Up slots 0..6 -> floors 1..7, down slots 7..13 -> floors 2..8.
  function automatic logic [3:0] slot_to_floor(input logic [3:0] s);
    if (s < 4'd7) return s + 4'd1;
    else          return s - 4'd5;
  endfunction

endpackage

// File: rtl/elevator_dispatch_if.sv
// elevator_dispatch_if: every signal between the dispatcher, the hall panel
// and the two car controllers.
//   slave  modport: dispatcher side (hall buttons and car status in; forwarded
//                   calls, lamps, busy and the FSM state debug view out).
//   master modport: panel/car side, the mirror image.
// Optional macro DISPATCH_STATS_EN adds the stat_a/stat_b dispatch counters.
// All signals are plain levels; there is no handshake. The forwarded call
// buses carry a registered pulse that the cars treat like a button press.
interface elevator_dispatch_if;
  import elevator_pkg::*;

  logic [7:1] hall_up;
  logic [8:2] hall_dn;
  logic [8:1] floor_a;
  logic [1:0] state_a;
  logic       en_a;
  logic [8:1] floor_b;
  logic [1:0] state_b;
  logic       en_b;
  logic [7:1] btup_a;
  logic [8:2] btdn_a;
  logic [7:1] btup_b;
  logic [8:2] btdn_b;
  logic [7:1] lamp_up;
  logic [8:2] lamp_dn;
  logic       busy;
  dispatch_state_e fsm_state;
`ifdef DISPATCH_STATS_EN
  logic [15:0] stat_a;
  logic [15:0] stat_b;
`endif

  modport slave (
    input  hall_up, hall_dn, floor_a, state_a, en_a, floor_b, state_b, en_b,
    output btup_a, btdn_a, btup_b, btdn_b, lamp_up, lamp_dn, busy, fsm_state
`ifdef DISPATCH_STATS_EN
    , output stat_a, stat_b
`endif
  );

  modport master (
    output hall_up, hall_dn, floor_a, state_a, en_a, floor_b, state_b, en_b,
    input  btup_a, btdn_a, btup_b, btdn_b, lamp_up, lamp_dn, busy, fsm_state
`ifdef DISPATCH_STATS_EN
    , input stat_a, stat_b
`endif
  );

endinterface

// File: rtl/elevator_dispatch_cost.sv
// dispatch_cost: combinational cost of sending one car to a target floor.
//   tf    : target floor 1..8
//   floor : car one-hot position, bit 0 = floor 1
//   state : car state (ST_OPEN/ST_DN/ST_UP/ST_CLOSE)
//   en    : car in service
//   cost  : distance plus AWAY_PENALTY when moving away, saturated at 31;
//           31 when the car is unavailable
//   avail : car is in service with a valid position
module dispatch_cost
  import elevator_pkg::*;
#(
  parameter int AWAY_PENALTY = 8
) (
  input  logic [3:0] tf,
  input  logic [7:0] floor,
  input  logic [1:0] state,
  input  logic       en,
  output logic [4:0] cost,
  output logic       avail
);

  logic [3:0] fa;
  int         raw;

  always_comb begin
    fa    = onehot_to_idx(floor);
    raw   = 0;
    avail = 1'b0;
    cost  = 5'd31;
    if (en && fa != 4'd0) begin
      avail = 1'b1;
      raw   = (tf > fa) ? int'(tf - fa) : int'(fa - tf);
      if ((state == ST_UP && tf < fa) || (state == ST_DN && tf > fa))
        raw = raw + AWAY_PENALTY;
      cost = (raw > 31) ? 5'd31 : 5'(raw);
    end
  end

endmodule

// File: rtl/elevator_dispatch.sv
// elevator_dispatch: group dispatcher for two cars sharing one hall panel.
// Latches hall calls into pend, picks the cheaper car per call round-robin
// from rr_ptr, forwards it as an ISSUE_CYCLES-long registered button pulse
// and keeps the hall lamp lit until the assigned car opens at that floor.
//   clk, rst (async, active low)
//   bus : elevator_dispatch_if.slave (hall buttons, car status, forwarded
//         calls, lamps, busy, fsm_state)
// Optional macro DISPATCH_STATS_EN adds saturating per-car dispatch counters.
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int ISSUE_CYCLES = 2,
  parameter int AWAY_PENALTY = 8
) (
  input  logic clk,
  input  logic rst,
  elevator_dispatch_if.slave bus
);

  dispatch_state_e state, state_nxt;
  logic [13:0] btn, pend, asg_a, asg_b, fwd_a, fwd_b;
  logic [13:0] served_a, served_b, pend_nxt, asg_a_nxt, asg_b_nxt, slot_oh;
  logic [3:0]  idx_a, idx_b, pick_slot, pick_tf, slot_q, rr_ptr;
  logic [2:0]  cnt;
  logic        tie_bit, en_a_q, en_b_q;
  logic        found, tie, pick_b, dispatch, issue_done;
  logic [4:0]  cost_a, cost_b;
  logic        avail_a, avail_b;
  int          j;

  assign btn = {bus.hall_dn, bus.hall_up};

  // A slot is served when the car stands with its door open at the target.
  always_comb begin
    idx_a    = onehot_to_idx(bus.floor_a);
    idx_b    = onehot_to_idx(bus.floor_b);
    served_a = '0;
    served_b = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      served_a[s] = (bus.state_a == ST_OPEN) && (idx_a == slot_to_floor(4'(s)));
      served_b[s] = (bus.state_b == ST_OPEN) && (idx_b == slot_to_floor(4'(s)));
    end
  end

  // Round-robin search for the first pending slot starting at rr_ptr.
  always_comb begin
    found     = 1'b0;
    pick_slot = rr_ptr;
    j         = 0;
    for (int i = 0; i < N_SLOTS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_SLOTS) j = j - N_SLOTS;
      if (!found && pend[j]) begin
        found     = 1'b1;
        pick_slot = 4'(j);
      end
    end
  end

  assign pick_tf = slot_to_floor(pick_slot);
  assign slot_oh = 14'd1 << pick_slot;

  dispatch_cost #(.AWAY_PENALTY(AWAY_PENALTY)) u_cost_a (
    .tf(pick_tf), .floor(bus.floor_a), .state(bus.state_a), .en(bus.en_a),
    .cost(cost_a), .avail(avail_a)
  );

  dispatch_cost #(.AWAY_PENALTY(AWAY_PENALTY)) u_cost_b (
    .tf(pick_tf), .floor(bus.floor_b), .state(bus.state_b), .en(bus.en_b),
    .cost(cost_b), .avail(avail_b)
  );

  // Winner selection; a lone available car wins even at saturated cost.
  always_comb begin
    tie    = 1'b0;
    pick_b = 1'b0;
    if (avail_a && avail_b) begin
      if (cost_a < cost_b)      pick_b = 1'b0;
      else if (cost_b < cost_a) pick_b = 1'b1;
      else begin
        tie    = 1'b1;
        pick_b = tie_bit;
      end
    end else begin
      pick_b = avail_b;
    end
  end

  always_comb begin
    state_nxt  = state;
    dispatch   = 1'b0;
    issue_done = 1'b0;
    case (state)
      DS_IDLE:  if (pend != '0 && (bus.en_a || bus.en_b)) state_nxt = DS_PICK;
      DS_PICK: begin
        if (found && (avail_a || avail_b)) begin
          dispatch  = 1'b1;
          state_nxt = DS_ISSUE;
        end else begin
          state_nxt = DS_IDLE;
        end
      end
      DS_ISSUE: begin
        if (cnt == 3'(ISSUE_CYCLES - 1)) begin
          issue_done = 1'b1;
          state_nxt  = (pend != '0) ? DS_PICK : DS_IDLE;
        end
      end
      default:  state_nxt = DS_IDLE;
    endcase
  end

  // Call masks. A car that dropped out of service one sample ago hands its
  // assignments back to pend, except the slot whose pulse is still running.
  always_comb begin
    pend_nxt  = pend | (btn & ~asg_a & ~asg_b);
    asg_a_nxt = asg_a & ~served_a;
    asg_b_nxt = asg_b & ~served_b;
    if (dispatch) begin
      pend_nxt = pend_nxt & ~slot_oh;
      if (pick_b) asg_b_nxt = asg_b_nxt | slot_oh;
      else        asg_a_nxt = asg_a_nxt | slot_oh;
    end
    if (!en_a_q && !(state == DS_ISSUE && fwd_a != '0) && !(dispatch && !pick_b)) begin
      pend_nxt  = pend_nxt | asg_a_nxt;
      asg_a_nxt = '0;
    end
    if (!en_b_q && !(state == DS_ISSUE && fwd_b != '0) && !(dispatch && pick_b)) begin
      pend_nxt  = pend_nxt | asg_b_nxt;
      asg_b_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DS_IDLE;
      pend    <= '0;
      asg_a   <= '0;
      asg_b   <= '0;
      fwd_a   <= '0;
      fwd_b   <= '0;
      slot_q  <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      tie_bit <= 1'b0;
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      asg_a  <= asg_a_nxt;
      asg_b  <= asg_b_nxt;
      en_a_q <= bus.en_a;
      en_b_q <= bus.en_b;
      if (dispatch) begin
        slot_q <= pick_slot;
        cnt    <= '0;
        if (pick_b) fwd_b <= slot_oh;
        else        fwd_a <= slot_oh;
        if (tie) tie_bit <= ~tie_bit;
      end else if (issue_done) begin
        fwd_a  <= '0;
        fwd_b  <= '0;
        rr_ptr <= (slot_q == 4'd13) ? 4'd0 : slot_q + 4'd1;
      end else if (state == DS_ISSUE) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign bus.btup_a    = fwd_a[6:0];
  assign bus.btdn_a    = fwd_a[13:7];
  assign bus.btup_b    = fwd_b[6:0];
  assign bus.btdn_b    = fwd_b[13:7];
  assign bus.lamp_up   = pend[6:0]  | asg_a[6:0]  | asg_b[6:0];
  assign bus.lamp_dn   = pend[13:7] | asg_a[13:7] | asg_b[13:7];
  assign bus.busy      = (state != DS_IDLE);
  assign bus.fsm_state = state;

`ifdef DISPATCH_STATS_EN
  logic [15:0] stat_a_q, stat_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
    end else if (dispatch) begin
      if (pick_b && stat_b_q != 16'hFFFF)  stat_b_q <= stat_b_q + 16'd1;
      if (!pick_b && stat_a_q != 16'hFFFF) stat_a_q <= stat_a_q + 16'd1;
    end
  end

  assign bus.stat_a = stat_a_q;
  assign bus.stat_b = stat_b_q;
`endif

endmodule

// File: tb/tb_elevator_dispatch.sv
// tb_elevator_dispatch: directed bench for elevator_dispatch.
module tb_elevator_dispatch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [3:0] exp_q[$];

  elevator_dispatch_if bus_if();

  elevator_dispatch #(.ISSUE_CYCLES(2), .AWAY_PENALTY(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_cars(input logic [8:1] fa, input logic [1:0] sa,
                          input logic [8:1] fb, input logic [1:0] sb);
    bus_if.floor_a = fa;
    bus_if.state_a = sa;
    bus_if.floor_b = fb;
    bus_if.state_b = sb;
    bus_if.en_a    = 1'b1;
    bus_if.en_b    = 1'b1;
  endtask

  task automatic reset_dut();
    rst            = 1'b0;
    bus_if.hall_up = '0;
    bus_if.hall_dn = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic press(input logic [7:1] up, input logic [8:2] dn);
    bus_if.hall_up = up;
    bus_if.hall_dn = dn;
    tick();
    bus_if.hall_up = '0;
    bus_if.hall_dn = '0;
  endtask

  function automatic logic [27:0] all_fwd();
    return {bus_if.btdn_b, bus_if.btup_b, bus_if.btdn_a, bus_if.btup_a};
  endfunction

  // Bounded wait for any forwarded bit.
  task automatic wait_fwd(input string tag);
    int n;
    n = 0;
    while (all_fwd() == '0 && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(all_fwd() != '0), 32'd1);
  endtask

  initial begin
    logic [13:0] cur, prev;
    int slot;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    set_cars(8'b0000_0001, 2'b11, 8'b1000_0000, 2'b11);
    bus_if.hall_up = '0;
    bus_if.hall_dn = '0;
    tick();
    check("rst_fwd",  32'(all_fwd()), 32'd0);
    check("rst_lamp", 32'({bus_if.lamp_dn, bus_if.lamp_up}), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);

    // Test 1: exact latency, pulse width and service clear.
    reset_dut();
    press(7'b0000010, '0);                        // E0
    check("t1_lamp_e0", 32'(bus_if.lamp_up), 32'h02);
    check("t1_busy_e0", 32'(bus_if.busy), 32'd0);
    tick();                                       // E1 PICK
    check("t1_busy_e1", 32'(bus_if.busy), 32'd1);
    check("t1_fwd_e1",  32'(all_fwd()), 32'd0);
    tick();                                       // E2
    check("t1_btup_a_e2", 32'(bus_if.btup_a), 32'h02);
    check("t1_btup_b_e2", 32'(bus_if.btup_b), 32'd0);
    tick();                                       // E3
    check("t1_btup_a_e3", 32'(bus_if.btup_a), 32'h02);
    tick();                                       // E4
    check("t1_btup_a_e4", 32'(bus_if.btup_a), 32'd0);
    check("t1_busy_e4",   32'(bus_if.busy), 32'd0);
    check("t1_lamp_e4",   32'(bus_if.lamp_up), 32'h02);
    bus_if.floor_a = 8'b0000_0010;
    bus_if.state_a = 2'b00;
    tick();
    check("t1_lamp_served", 32'(bus_if.lamp_up), 32'd0);

    // Test 2: equal costs alternate A then B.
    set_cars(8'b0000_1000, 2'b11, 8'b0000_1000, 2'b11);
    reset_dut();
    press('0, 7'b0010000);                        // down at floor 6
    wait_fwd("t2a");
    check("t2_btdn_a", 32'(bus_if.btdn_a), 32'h10);
    check("t2_btdn_b", 32'(bus_if.btdn_b), 32'd0);
    repeat (4) tick();
    press(7'b0000100, '0);                        // up at floor 3
    wait_fwd("t2b");
    check("t2_btup_b", 32'(bus_if.btup_b), 32'h04);
    check("t2_btup_a", 32'(bus_if.btup_a), 32'd0);
    repeat (4) tick();

    // Test 3: A moving away (cost 10) loses to B (cost 1).
    set_cars(8'b0001_0000, 2'b10, 8'b0000_0010, 2'b11);
    reset_dut();
    press(7'b0000100, '0);
    wait_fwd("t3");
    check("t3_btup_b", 32'(bus_if.btup_b), 32'h04);
    check("t3_btup_a", 32'(bus_if.btup_a), 32'd0);
    repeat (4) tick();

    // Test 4: no car in service, then B returns.
    set_cars(8'b0000_0001, 2'b11, 8'b1000_0000, 2'b11);
    bus_if.en_a = 1'b0;
    bus_if.en_b = 1'b0;
    reset_dut();
    press('0, 7'b0001000);                        // down at floor 5
    repeat (5) tick();
    check("t4_busy_off", 32'(bus_if.busy), 32'd0);
    check("t4_lamp",     32'(bus_if.lamp_dn), 32'h08);
    check("t4_no_fwd",   32'(all_fwd()), 32'd0);
    bus_if.en_b = 1'b1;
    wait_fwd("t4");
    check("t4_btdn_b", 32'(bus_if.btdn_b), 32'h08);
    check("t4_btdn_a", 32'(bus_if.btdn_a), 32'd0);
    repeat (4) tick();

    // Test 5: every button held; scoreboard expects slots 0..13 in order.
    set_cars(8'b0000_0001, 2'b11, 8'b1000_0000, 2'b11);
    reset_dut();
    for (int s = 0; s < 14; s++) exp_q.push_back(4'(s));
    bus_if.hall_up = 7'h7F;
    bus_if.hall_dn = 7'h7F;
    prev = '0;
    for (int c = 0; c < 60; c++) begin
      tick();
      cur = {bus_if.btdn_a, bus_if.btup_a} | {bus_if.btdn_b, bus_if.btup_b};
      if (cur != '0)
        check("t5_single_fwd", 32'($countones(all_fwd())), 32'd1);
      if (prev == '0 && cur != '0) begin
        slot = 0;
        for (int k = 0; k < 14; k++) if (cur[k]) slot = k;
        if (exp_q.size() == 0) check("t5_extra_dispatch", 32'(slot), 32'd99);
        else                   check("t5_slot_order", 32'(slot), 32'(exp_q.pop_front()));
      end
      prev = cur;
    end
    check("t5_all_dispatched", 32'(exp_q.size()), 32'd0);
    bus_if.hall_up = '0;
    bus_if.hall_dn = '0;
    tick();
    check("t5_lamps", 32'({bus_if.lamp_dn, bus_if.lamp_up}), 32'h3FFF);
    check("t5_busy",  32'(bus_if.busy), 32'd0);

    // Test 6: reset mid-pulse clears everything at once.
    set_cars(8'b0000_0001, 2'b11, 8'b1000_0000, 2'b11);
    reset_dut();
    press(7'b0000010, '0);
    wait_fwd("t6");
    rst = 1'b0;
    #1;
    check("t6_fwd_now",  32'(all_fwd()), 32'd0);
    check("t6_lamp_now", 32'({bus_if.lamp_dn, bus_if.lamp_up}), 32'd0);
    check("t6_busy_now", 32'(bus_if.busy), 32'd0);
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("t6_busy_after", 32'(bus_if.busy), 32'd0);
    check("t6_lamp_after", 32'(bus_if.lamp_up), 32'd0);
    press(7'b0001000, '0);
    tick();
    check("t6_busy_press", 32'(bus_if.busy), 32'd1);
    repeat (5) tick();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
